// File: rtl/nonce_hub_rr.sv
// Nonce collection hub: per-slave rising-edge capture into pending slots, round-robin
// drain into a tagged FIFO, and a handshake FSM feeding one word at a time to serial_transmit.
module nonce_hub_rr #(
  parameter int SLAVES     = 3,
  parameter int NONCE_W    = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16,
  localparam int SLAVE_W   = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]         new_nonces,
  output logic                      serial_send,
  input  logic                      serial_busy,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic [SLAVE_W-1:0]        golden_slave,
  output logic                      found_pulse,
  output logic [LVL_W-1:0]          fifo_level,
  output logic [DROP_W-1:0]         drop_count,
  output logic                      overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENT_W   = SLAVE_W + NONCE_W;
  localparam int NDROP_W = $clog2(SLAVES + 1);
  localparam int SUM_W   = ((DROP_W > NDROP_W) ? DROP_W : NDROP_W) + 1;
  localparam logic [DROP_W-1:0]  DROP_MAX = '1;
  localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [SLAVE_W-1:0] LAST_IDX = SLAVE_W'(SLAVES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  function automatic logic [DROP_W-1:0] sat_drop(input logic [SUM_W-1:0] s);
    if (s > SUM_W'(DROP_MAX)) return DROP_MAX;
    return s[DROP_W-1:0];
  endfunction

  function automatic logic [SLAVE_W-1:0] rr_idx(input logic [SLAVE_W-1:0] base, input int k);
    int j;
    j = (int'(base) + k) % SLAVES;
    return SLAVE_W'(j);
  endfunction

  logic [SLAVES-1:0]  prev_q;
  logic [SLAVES-1:0]  pend_vld_q, pend_vld_d;
  logic [NONCE_W-1:0] pend_q [SLAVES];
  logic [SLAVE_W-1:0] rr_q, rr_d;
  logic [SLAVES-1:0]  cap, gnt_oh, acc, drop;
  logic               gnt_vld;
  logic [SLAVE_W-1:0] gnt_idx;
  logic [NDROP_W-1:0] ndrop;
  logic [SUM_W-1:0]   drop_sum;
  logic               found_q;
  logic [DROP_W-1:0]  drop_q;
  logic               ovf_q;

  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [LVL_W-1:0]   cnt_q, cnt_d;
  logic               full, push, pop;

  state_t             state_q;
  logic               send_q;
  logic [NONCE_W-1:0] golden_q;
  logic [SLAVE_W-1:0] gslave_q;

  assign cap  = new_nonces & ~prev_q;
  assign full = (cnt_q == FULL_LVL);
  assign push = gnt_vld;
  assign pop  = (state_q == IDLE) && (cnt_q != '0) && !serial_busy;

  // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!full) begin
      for (int k = 0; k < SLAVES; k++) begin
        if (!gnt_vld && pend_vld_q[rr_idx(rr_q, k)]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx(rr_q, k);
        end
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    acc        = cap & (~pend_vld_q | gnt_oh);
    drop       = cap & pend_vld_q & ~gnt_oh;
    pend_vld_d = (pend_vld_q & ~gnt_oh) | acc;
    rr_d       = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SLAVE_W'(1);
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < SLAVES; i++) ndrop = ndrop + NDROP_W'(drop[i]);
    drop_sum = SUM_W'(drop_q) + SUM_W'(ndrop);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + LVL_W'(1);
    else if (!push && pop) cnt_d = cnt_q - LVL_W'(1);
  end

  // Capture / arbitration state
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      pend_vld_q <= '0;
      rr_q       <= '0;
      found_q    <= 1'b0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      prev_q     <= new_nonces;
      pend_vld_q <= pend_vld_d;
      rr_q       <= rr_d;
      found_q    <= |acc;
      if (|drop) begin
        drop_q <= sat_drop(drop_sum);
        ovf_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < SLAVES; i++) begin
      if (acc[i]) pend_q[i] <= slave_nonces[i*NONCE_W +: NONCE_W];
    end
    if (push) mem_q[wptr_q] <= {gnt_idx, pend_q[gnt_idx]};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Transmit handshake
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      send_q   <= 1'b0;
      golden_q <= '0;
      gslave_q <= '0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            {gslave_q, golden_q} <= mem_q[rptr_q];
            send_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND:      state_q <= WAIT_ACK;
        WAIT_ACK:  if (serial_busy) state_q <= WAIT_DONE;
        WAIT_DONE: if (!serial_busy) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign serial_send  = send_q;
  assign golden_nonce = golden_q;
  assign golden_slave = gslave_q;
  assign found_pulse  = found_q;
  assign fifo_level   = cnt_q;
  assign drop_count   = drop_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_nonce_hub_rr.sv
// Bench for nonce_hub_rr: queue-based reference model compared every cycle, plus literal
// expectations for latency, arbitration order, backpressure, saturation and mid-transfer reset.
module tb_nonce_hub_rr;
  localparam int S  = 3;
  localparam int NW = 32;
  localparam int FD = 8;
  localparam int BL = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [S*NW-1:0] nonces;
  logic [S-1:0]  strobes;
  logic          busy;

  logic          send, found, ovf;
  logic [NW-1:0] gn;
  logic [1:0]    gs;
  logic [3:0]    lvl;
  logic [15:0]   drop;

  logic          send2, found2, ovf2;
  logic [NW-1:0] gn2;
  logic [1:0]    gs2;
  logic [3:0]    lvl2;
  logic [1:0]    drop2;

  nonce_hub_rr #(.SLAVES(S), .NONCE_W(NW), .FIFO_DEPTH(FD), .DROP_W(16)) dut (
    .hash_clk(clk), .reset(rst), .slave_nonces(nonces), .new_nonces(strobes),
    .serial_send(send), .serial_busy(busy), .golden_nonce(gn), .golden_slave(gs),
    .found_pulse(found), .fifo_level(lvl), .drop_count(drop), .overflow(ovf));

  nonce_hub_rr #(.SLAVES(S), .NONCE_W(NW), .FIFO_DEPTH(FD), .DROP_W(2)) dut2 (
    .hash_clk(clk), .reset(rst), .slave_nonces(nonces), .new_nonces(strobes),
    .serial_send(send2), .serial_busy(busy), .golden_nonce(gn2), .golden_slave(gs2),
    .found_pulse(found2), .fifo_level(lvl2), .drop_count(drop2), .overflow(ovf2));

  always #5 clk = ~clk;

  typedef struct {int s; logic [NW-1:0] n;} ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [S-1:0]  m_prev, m_pv;
  logic [NW-1:0] m_pend [S];
  int            m_rr, m_ph, m_drops, m_gs;
  ent_t          m_q[$];
  bit            m_send, m_found, m_ovf;
  logic [NW-1:0] m_gn;

  // bench bookkeeping
  int   tx_cnt = 0;
  bit   busy_hold = 0;
  int   found_cnt, send_cnt;
  ent_t sent[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pv = '0; m_rr = 0; m_ph = 0; m_drops = 0; m_gs = 0;
    m_q.delete(); m_send = 0; m_found = 0; m_ovf = 0; m_gn = '0;
  endtask

  task automatic model_step();
    logic [S-1:0] cap;
    int g;
    ent_t e;
    bit do_pop;
    cap = strobes & ~m_prev;
    g = -1;
    if (m_q.size() < FD) begin
      for (int k = 0; k < S; k++) begin
        int j;
        j = (m_rr + k) % S;
        if (g < 0 && m_pv[j]) g = j;
      end
    end
    do_pop = (m_ph == 0) && (m_q.size() > 0) && !busy;
    if (g >= 0) begin
      e.s = g; e.n = m_pend[g];
      m_pv[g] = 1'b0;
      m_rr = (g + 1) % S;
    end
    m_found = 0;
    for (int i = 0; i < S; i++) begin
      if (cap[i]) begin
        if (!m_pv[i]) begin
          m_pend[i] = nonces[i*NW +: NW];
          m_pv[i] = 1'b1;
          m_found = 1;
        end else begin
          m_drops++;
          m_ovf = 1;
        end
      end
    end
    if (do_pop) begin
      ent_t h;
      h = m_q.pop_front();
      m_gn = h.n; m_gs = h.s;
    end
    if (g >= 0) m_q.push_back(e);
    case (m_ph)
      0: if (do_pop) m_ph = 1;
      1: m_ph = 2;
      2: if (busy) m_ph = 3;
      default: if (!busy) m_ph = 0;
    endcase
    m_send = (m_ph == 1);
    m_prev = strobes;
  endtask

  task automatic compare_all();
    chk("serial_send", 64'(send), 64'(m_send));
    chk("found_pulse", 64'(found), 64'(m_found));
    chk("fifo_level", 64'(lvl), 64'(m_q.size()));
    chk("drop_count", 64'(drop), 64'(sat(m_drops, 65535)));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("golden_nonce", 64'(gn), 64'(m_gn));
    chk("golden_slave", 64'(gs), 64'(m_gs));
    chk("drop_count_w2", 64'(drop2), 64'(sat(m_drops, 3)));
    chk("fifo_level_w2", 64'(lvl2), 64'(m_q.size()));
  endtask

  task automatic step();
    if (!rst) model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (found) found_cnt++;
    if (send) begin
      ent_t r;
      r.s = int'(gs); r.n = gn;
      sent.push_back(r);
      send_cnt++;
    end
    if (busy_hold) busy = 1'b1;
    else begin
      if (tx_cnt > 0) begin busy = 1'b1; tx_cnt--; end
      else busy = 1'b0;
      if (m_send) tx_cnt = BL;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    tx_cnt = 0;
    busy = busy_hold;
    compare_all();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic clear_stats();
    found_cnt = 0; send_cnt = 0; sent.delete();
  endtask

  initial begin
    rst = 1'b1; strobes = '0; nonces = '0; busy = 1'b0;
    model_reset();
    clear_stats();
    #2;
    do_reset();

    // 1: single capture, 3-cycle latency
    nonces[1*NW +: NW] = 32'hDEADBEEF;
    strobes = 3'b010;
    step();
    chk("t1_found", 64'(found), 64'd1);
    step();
    step();
    chk("t1_send", 64'(send), 64'd1);
    chk("t1_gnonce", 64'(gn), 64'hDEADBEEF);
    chk("t1_gslave", 64'(gs), 64'd1);
    strobes = '0;
    repeat (20) step();
    chk("t1_found_once", 64'(found_cnt), 64'd1);

    // 2b: rr pointer at 2 after slave1 was granted
    clear_stats();
    nonces = {32'hC2, 32'hB1, 32'hA0};
    strobes = 3'b111; step(); strobes = '0;
    repeat (60) step();
    chk("t2b_count", 64'(sent.size()), 64'd3);
    if (sent.size() == 3) begin
      chk("t2b_ord0", 64'(sent[0].s), 64'd2);
      chk("t2b_ord1", 64'(sent[1].s), 64'd0);
      chk("t2b_ord2", 64'(sent[2].s), 64'd1);
      chk("t2b_n0", 64'(sent[0].n), 64'hC2);
    end

    // 2a: after reset rr pointer is 0
    do_reset();
    clear_stats();
    strobes = 3'b111; step(); strobes = '0;
    repeat (60) step();
    chk("t2a_count", 64'(sent.size()), 64'd3);
    if (sent.size() == 3) begin
      chk("t2a_ord0", 64'(sent[0].s), 64'd0);
      chk("t2a_ord1", 64'(sent[1].s), 64'd1);
      chk("t2a_ord2", 64'(sent[2].s), 64'd2);
      chk("t2a_n2", 64'(sent[2].n), 64'hC2);
    end

    // 3: held strobe captures once
    clear_stats();
    strobes = 3'b001;
    repeat (20) step();
    strobes = '0;
    repeat (20) step();
    chk("t3_found", 64'(found_cnt), 64'd1);
    chk("t3_drop", 64'(drop), 64'd0);

    // 4: backpressure fills FIFO and pendings, then one drop
    busy_hold = 1;
    do_reset();
    clear_stats();
    for (int p = 0; p < 4; p++) begin
      nonces = {32'h300 + 32'(p), 32'h200 + 32'(p), 32'h100 + 32'(p)};
      strobes = 3'b111; step(); strobes = '0;
      repeat (3) step();
    end
    chk("t4_level", 64'(lvl), 64'd8);
    chk("t4_drop", 64'(drop), 64'd1);
    chk("t4_ovf", 64'(ovf), 64'd1);

    // 5: further drops on a pending slave; narrow counter saturates
    for (int p = 0; p < 5; p++) begin
      strobes = 3'b001; step(); strobes = '0; step();
    end
    chk("t5_drop16", 64'(drop), 64'd6);
    chk("t5_drop2", 64'(drop2), 64'd3);

    busy_hold = 0;
    busy = 1'b0;
    repeat (220) step();
    chk("t4_sent", 64'(send_cnt), 64'd11);
    chk("t4_drained", 64'(lvl), 64'd0);

    // 6: reset while waiting for busy to fall with 4 words queued
    do_reset();
    clear_stats();
    nonces = {32'h33, 32'h22, 32'h11};
    strobes = 3'b111; step(); strobes = '0;
    repeat (3) step();
    strobes = 3'b011; step(); strobes = '0;
    repeat (4) step();
    chk("t6_level", 64'(lvl), 64'd4);
    chk("t6_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_level", 64'(lvl), 64'd0);
    chk("t6_rst_gnonce", 64'(gn), 64'd0);
    chk("t6_rst_send", 64'(send), 64'd0);
    chk("t6_rst_ovf", 64'(ovf), 64'd0);
    do_reset();
    clear_stats();
    repeat (20) step();
    chk("t6_no_send", 64'(send_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
